// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants, FSM encoding and request decode helpers for the vscale dmem responder.
package vscale_dmem_responder_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW = 3'd2;

  localparam int DMEM_STATE_WIDTH = 2;

  typedef enum logic [DMEM_STATE_WIDTH-1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DATA = 2'd2
  } dmem_state_e;

  // Request attributes latched at the address phase; the word index is held separately
  // because its width depends on the SRAM depth.
  typedef struct packed {
    logic                      wen;
    logic [MEM_TYPE_WIDTH-1:0] size;
    logic [1:0]                off;
    logic                      err;
  } dmem_req_t;

  function automatic logic access_err(input logic [MEM_TYPE_WIDTH-1:0] size,
                                      input logic [1:0] off);
    case (size)
      MEM_TYPE_SB: access_err = 1'b0;
      MEM_TYPE_SH: access_err = off[0];
      MEM_TYPE_SW: access_err = (off != 2'b00);
      default:     access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [MEM_TYPE_WIDTH-1:0] size,
                                             input logic [1:0] off);
    case (size)
      MEM_TYPE_SB: store_lanes = 4'b0001 << off;
      MEM_TYPE_SH: store_lanes = 4'b0011 << off;
      default:     store_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/vscale_dmem_responder_sram.sv
// Word-wide SRAM with one synchronous read port and one byte-enabled write port.
// A read and write to the same word on one edge returns the old contents.
module vscale_dmem_responder_sram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_idx,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_idx];
    if (wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vscale_dmem_responder.sv
// Target-side data memory for the vscale dmem port: pipelined address/data phases,
// programmable wait states, access-error flagging and store-to-load forwarding.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int                 DEPTH_LOG2  = 12,
  parameter logic [XPR_LEN-1:0] BASE_ADDR   = '0,
  parameter int                 WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_wait,
  output logic                      dmem_badmem_e
);

  localparam int IDX_HI = DEPTH_LOG2 + 1;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  dmem_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  dmem_req_t          req_q, req_d;
  idx_t               idx_q, idx_d;
  logic               fwd_hit_q, fwd_hit_d;
  logic [3:0]         fwd_be_q, fwd_be_d;
  logic [XPR_LEN-1:0] fwd_data_q, fwd_data_d;

  logic               in_range;
  logic               sample;
  logic               st_we;
  logic [3:0]         st_be;
  idx_t               rd_idx;
  logic [XPR_LEN-1:0] sram_rdata;

  function automatic logic [XPR_LEN-1:0] merge_lanes(input logic [XPR_LEN-1:0] old_word,
                                                     input logic [XPR_LEN-1:0] new_word,
                                                     input logic [3:0] be);
    merge_lanes = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge_lanes[8*b +: 8] = new_word[8*b +: 8];
    end
  endfunction

  assign in_range = (dmem_addr[XPR_LEN-1:IDX_HI+1] == BASE_ADDR[XPR_LEN-1:IDX_HI+1]);
  assign sample   = dmem_en && (state_q != DMEM_WAIT);
  // During wait states the address bus carries the next request, so reads use the latched index.
  assign rd_idx   = (state_q == DMEM_WAIT) ? idx_q : dmem_addr[IDX_HI:2];
  assign st_we    = (state_q == DMEM_DATA) && req_q.wen && !req_q.err;
  assign st_be    = store_lanes(req_q.size, req_q.off);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    idx_d      = idx_q;
    fwd_hit_d  = st_we && (rd_idx == idx_q);
    fwd_be_d   = st_be;
    fwd_data_d = dmem_wdata_delayed;

    if (sample) begin
      req_d.wen  = dmem_wen;
      req_d.size = dmem_size;
      req_d.off  = dmem_addr[1:0];
      req_d.err  = !in_range || access_err(dmem_size, dmem_addr[1:0]);
      idx_d      = dmem_addr[IDX_HI:2];
    end

    case (state_q)
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) state_d = DMEM_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (!dmem_en) begin
          state_d = DMEM_IDLE;
        end else if (WAIT_CYCLES == 0) begin
          state_d = DMEM_DATA;
        end else begin
          state_d = DMEM_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DMEM_IDLE;
      cnt_q     <= 4'd0;
      fwd_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_hit_q <= fwd_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q      <= req_d;
    idx_q      <= idx_d;
    fwd_be_q   <= fwd_be_d;
    fwd_data_q <= fwd_data_d;
  end

  vscale_dmem_responder_sram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (XPR_LEN)
  ) u_sram (
    .clk     (clk),
    .rd_idx  (rd_idx),
    .rd_data (sram_rdata),
    .wr_en   (st_we),
    .wr_idx  (idx_q),
    .wr_be   (st_be),
    .wr_data (dmem_wdata_delayed)
  );

  assign dmem_wait     = (state_q == DMEM_WAIT);
  assign dmem_badmem_e = (state_q == DMEM_DATA) && req_q.err;
  assign dmem_rdata    = ((state_q == DMEM_DATA) && !req_q.wen && !req_q.err)
                         ? merge_lanes(sram_rdata, fwd_data_q, fwd_hit_q ? fwd_be_q : 4'b0000)
                         : '0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed and model-checked bench for vscale_dmem_responder, using a zero-wait
// instance and a three-wait-state instance side by side.
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  localparam int          DEPTH_LOG2 = 8;
  localparam logic [31:0] BASE       = 32'h0;
  localparam logic [31:0] LIMIT      = 32'h400;
  localparam int          W1         = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_s    [2];
  logic        wen_s   [2];
  logic [2:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        wait_s  [2];
  logic        bad_s   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vscale_dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .dmem_en(en_s[0]), .dmem_wen(wen_s[0]),
    .dmem_size(size_s[0]), .dmem_addr(addr_s[0]), .dmem_wdata_delayed(wdata_s[0]),
    .dmem_rdata(rdata_s[0]), .dmem_wait(wait_s[0]), .dmem_badmem_e(bad_s[0]));

  vscale_dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut3 (
    .clk(clk), .reset_n(reset_n), .dmem_en(en_s[1]), .dmem_wen(wen_s[1]),
    .dmem_size(size_s[1]), .dmem_addr(addr_s[1]), .dmem_wdata_delayed(wdata_s[1]),
    .dmem_rdata(rdata_s[1]), .dmem_wait(wait_s[1]), .dmem_badmem_e(bad_s[1]));

  typedef struct {
    logic        en;
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    txn_t        t;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_bad;
  } vec_t;

  function automatic int wc(input int d);
    return (d == 0) ? 0 : W1;
  endfunction

  function automatic txn_t mk(input logic en, input logic wen, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.en = en; t.wen = wen; t.size = size; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents one address phase (plus write data of the request in its data phase) and
  // returns the completion outputs of that earlier request. Called and returns at posedge+1.
  task automatic step(input int d, input txn_t t, input logic [31:0] wdata, input bit scramble,
                      output logic [31:0] rd, output logic bad, output int nwait);
    bit done;
    done = 0;
    nwait = 0;
    rd = '0;
    bad = 1'b0;
    wdata_s[d] = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      if (wait_s[d] && scramble) begin
        en_s[d] = 1'b1; wen_s[d] = 1'b1; size_s[d] = MEM_TYPE_SW; addr_s[d] = 32'h100;
      end else begin
        en_s[d] = t.en; wen_s[d] = t.wen; size_s[d] = t.size; addr_s[d] = t.addr;
      end
      if (wait_s[d]) nwait++;
      @(negedge clk);
      if (!wait_s[d]) begin
        rd = rdata_s[d];
        bad = bad_s[d];
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL step_timeout dut=%0d actual=wait_stuck required=completion", d);
    end
  endtask

  task automatic check_done(input int d, input string tag, input txn_t p, input logic chk_rd,
                            input logic [31:0] exp_rd, input logic exp_bad,
                            input logic [31:0] rd, input logic bad, input int nw);
    chk({tag, "_bad"}, 32'(bad), 32'(exp_bad));
    if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_waits"}, 32'(nw), p.en ? 32'(wc(d)) : 32'd0);
  endtask

  function automatic bit mdl_err(input txn_t t);
    if (t.addr >= LIMIT) return 1;
    if (t.size == 3'd1 && t.addr[0]) return 1;
    if (t.size == 3'd2 && t.addr[1:0] != 2'b00) return 1;
    if (t.size > 3'd2) return 1;
    return 0;
  endfunction

  task automatic run_random(input int d, input int n);
    logic [31:0] mdl [256];
    txn_t        cur, prev;
    logic [31:0] rd, exp_rd, v;
    logic        bad, exp_bad, chk_rd;
    int          nw, sel, off;
    prev = mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i <= n; i++) begin
      v = $urandom;
      if (i == n) begin
        cur = mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      end else if (i < 8) begin
        cur = mk(1'b1, 1'b1, MEM_TYPE_SW, 32'h100 + 32'(4 * i), v);
      end else begin
        sel = $urandom_range(0, 9);
        cur.en  = ($urandom_range(0, 15) != 0);
        cur.wen = 1'($urandom_range(0, 1));
        cur.size = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd2 : 3'($urandom_range(3, 7));
        off = $urandom_range(0, 31);
        if ($urandom_range(0, 3) != 0) begin
          if (cur.size == 3'd1) off = off & ~1;
          if (cur.size == 3'd2) off = off & ~3;
        end
        cur.addr = 32'h100 + 32'(off);
        if ($urandom_range(0, 15) == 0) cur.addr = LIMIT + 32'($urandom_range(0, 255));
        cur.wdata = (cur.size == 3'd0) ? {4{v[7:0]}} : (cur.size == 3'd1) ? {2{v[15:0]}} : v;
      end
      step(d, cur, prev.wdata, d == 1, rd, bad, nw);
      chk_rd = 1'b1;
      exp_rd = '0;
      exp_bad = 1'b0;
      if (prev.en) begin
        if (mdl_err(prev)) begin
          exp_bad = 1'b1;
        end else if (prev.wen) begin
          chk_rd = 1'b0;
          for (int b = 0; b < 4; b++) begin
            if ((prev.size == 3'd2) ||
                (prev.size == 3'd1 && (b == prev.addr[1:0] || b == prev.addr[1:0] + 1)) ||
                (prev.size == 3'd0 && b == prev.addr[1:0]))
              mdl[prev.addr[9:2]][8*b +: 8] = prev.wdata[8*b +: 8];
          end
        end else begin
          exp_rd = mdl[prev.addr[9:2]];
        end
      end
      check_done(d, $sformatf("rnd_d%0d_%0d", d, i), prev, chk_rd, exp_rd, exp_bad, rd, bad, nw);
      prev = cur;
    end
  endtask

  vec_t        tbl [22];
  logic [31:0] rd;
  logic        bad;
  int          nw;
  txn_t        nop;

  initial begin
    for (int d = 0; d < 2; d++) begin
      en_s[d] = 1'b0; wen_s[d] = 1'b0; size_s[d] = 3'd0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    nop = mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    tbl[0]  = '{mk(1, 1, MEM_TYPE_SW, 32'h100, 32'h12345678), 0, 32'h0,        0};
    tbl[1]  = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12345678, 0};
    tbl[2]  = '{mk(1, 1, MEM_TYPE_SB, 32'h102, 32'hABABABAB), 0, 32'h0,        0};
    tbl[3]  = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12AB5678, 0};
    tbl[4]  = '{mk(0, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h0,        0};
    tbl[5]  = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12AB5678, 0};
    tbl[6]  = '{mk(1, 1, MEM_TYPE_SH, 32'h101, 32'hBEEFBEEF), 1, 32'h0,        1};
    tbl[7]  = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12AB5678, 0};
    tbl[8]  = '{mk(1, 0, MEM_TYPE_SW, LIMIT,   32'h0),        1, 32'h0,        1};
    tbl[9]  = '{mk(1, 1, MEM_TYPE_SW, 32'h104, 32'h00000000), 0, 32'h0,        0};
    tbl[10] = '{mk(1, 1, MEM_TYPE_SH, 32'h106, 32'hCAFECAFE), 0, 32'h0,        0};
    tbl[11] = '{mk(1, 0, MEM_TYPE_SW, 32'h104, 32'h0),        1, 32'hCAFE0000, 0};
    tbl[12] = '{mk(1, 1, MEM_TYPE_SB, 32'h107, 32'h11111111), 0, 32'h0,        0};
    tbl[13] = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12AB5678, 0};
    tbl[14] = '{mk(1, 0, MEM_TYPE_SW, 32'h104, 32'h0),        1, 32'h11FE0000, 0};
    tbl[15] = '{mk(1, 0, 3'd3,        32'h108, 32'h0),        1, 32'h0,        1};
    tbl[16] = '{mk(1, 0, MEM_TYPE_SH, 32'h102, 32'h0),        1, 32'h12AB5678, 0};
    tbl[17] = '{mk(1, 1, MEM_TYPE_SW, 32'h3FC, 32'h55AA55AA), 0, 32'h0,        0};
    tbl[18] = '{mk(1, 0, MEM_TYPE_SW, 32'h3FC, 32'h0),        1, 32'h55AA55AA, 0};
    tbl[19] = '{mk(1, 1, MEM_TYPE_SW, 32'h102, 32'hA5A5A5A5), 1, 32'h0,        1};
    tbl[20] = '{mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0),        1, 32'h12AB5678, 0};
    tbl[21] = '{mk(1, 0, MEM_TYPE_SB, 32'h103, 32'h0),        1, 32'h12AB5678, 0};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_wait_d%0d", d), 32'(wait_s[d]), 32'd0);
      chk($sformatf("reset_bad_d%0d", d), 32'(bad_s[d]), 32'd0);
      chk($sformatf("reset_rdata_d%0d", d), rdata_s[d], 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i <= 22; i++) begin
        step(d, (i < 22) ? tbl[i].t : nop, (i > 0) ? tbl[i-1].t.wdata : 32'h0, d == 1, rd, bad, nw);
        if (i == 0)
          check_done(d, $sformatf("dir_d%0d_idle", d), nop, 1, 32'h0, 0, rd, bad, nw);
        else
          check_done(d, $sformatf("dir_d%0d_v%0d", d, i - 1), tbl[i-1].t, tbl[i-1].chk_rd,
                     tbl[i-1].exp_rd, tbl[i-1].exp_bad, rd, bad, nw);
      end
    end

    step(1, mk(1, 1, MEM_TYPE_SW, 32'h100, 32'h99999999), 32'h0, 0, rd, bad, nw);
    check_done(1, "rst_pre", nop, 1, 32'h0, 0, rd, bad, nw);
    wdata_s[1] = 32'h99999999;
    en_s[1] = 1'b0;
    #2;
    chk("rst_in_wait", 32'(wait_s[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_wait", 32'(wait_s[1]), 32'd0);
    chk("rst_async_bad", 32'(bad_s[1]), 32'd0);
    chk("rst_async_rdata", rdata_s[1], 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0), 32'h0, 0, rd, bad, nw);
    check_done(1, "rst_post_idle", nop, 1, 32'h0, 0, rd, bad, nw);
    step(1, nop, 32'h0, 0, rd, bad, nw);
    check_done(1, "rst_store_dropped", mk(1, 0, MEM_TYPE_SW, 32'h100, 32'h0), 1,
               32'h12AB5678, 0, rd, bad, nw);

    run_random(0, 150);
    run_random(1, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
